// File: rtl/minimicro_dmem_responder_if.sv
// Load/store bus between the minimicro core (master) and its data-memory responder (slave).
// Request and response are independent valid/ready channels.
interface minimicro_dmem_responder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [3:0]            req_op_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_err_o;

    modport master (
        output req_valid_i, req_op_i, req_addr_i, req_wdata_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_addr_i, req_wdata_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/minimicro_dmem_responder.sv
// Data-memory responder for the minimicro core: one outstanding LDR/STR with programmable wait states.
// Optional DMEM_RESET_CLEAR_EN adds a post-reset sweep that zeroes the whole array.
module minimicro_dmem_responder #(
    parameter int DATA_WIDTH   = 16,
    parameter int DM_ADDRESSES = 256,
    parameter int ADDR_WIDTH   = 8,
    parameter int WAIT_STATES  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    minimicro_dmem_responder_if.slave bus,
    output logic                     busy_o
);
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
    localparam logic [ADDR_WIDTH:0] DM_LIMIT = (ADDR_WIDTH + 1)'(DM_ADDRESSES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
`ifdef DMEM_RESET_CLEAR_EN
        S_CLEAR,
`endif
        S_RESP
    } state_t;

    state_t                r_state;
    logic [3:0]            r_waitCnt;
    logic [3:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_reqReady;
    logic                  r_rspValid;
    logic [DATA_WIDTH-1:0] r_rspRdata;
    logic                  r_rspErr;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_mem [0:DM_ADDRESSES-1];
`ifdef DMEM_RESET_CLEAR_EN
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(DM_ADDRESSES - 1);
    logic [ADDR_WIDTH-1:0] r_clrAddr;
`endif

    logic                  w_opLegal;
    logic                  w_addrOk;
    logic                  w_legal;
    logic                  w_memWe;
    logic [ADDR_WIDTH-1:0] w_memWaddr;
    logic [DATA_WIDTH-1:0] w_memWdata;
    logic [DATA_WIDTH-1:0] w_memRdata;

    assign w_opLegal  = (r_op == OP_LDR) || (r_op == OP_STR);
    assign w_addrOk   = ({1'b0, r_addr} < DM_LIMIT);
    assign w_legal    = w_opLegal && w_addrOk;
    assign w_memRdata = w_addrOk ? r_mem[r_addr] : '0;

    // Gating with rst_n drops a store whose ACCESS edge coincides with reset.
    always_comb begin
        w_memWe    = 1'b0;
        w_memWaddr = r_addr;
        w_memWdata = r_wdata;
        if ((r_state == S_ACCESS) && w_legal && (r_op == OP_STR)) begin
            w_memWe = rst_n;
        end
`ifdef DMEM_RESET_CLEAR_EN
        if (r_state == S_CLEAR) begin
            w_memWe    = rst_n;
            w_memWaddr = r_clrAddr;
            w_memWdata = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (w_memWe) begin
            r_mem[w_memWaddr] <= w_memWdata;
        end
    end

    // Response becomes valid one cycle after entering RESP, giving WAIT_STATES+2 latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waitCnt  <= '0;
            r_op       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rspValid <= 1'b0;
            r_rspRdata <= '0;
            r_rspErr   <= 1'b0;
`ifdef DMEM_RESET_CLEAR_EN
            r_state    <= S_CLEAR;
            r_reqReady <= 1'b0;
            r_busy     <= 1'b1;
            r_clrAddr  <= '0;
`else
            r_state    <= S_IDLE;
            r_reqReady <= 1'b1;
            r_busy     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid_i && r_reqReady) begin
                        r_op       <= bus.req_op_i;
                        r_addr     <= bus.req_addr_i;
                        r_wdata    <= bus.req_wdata_i;
                        r_reqReady <= 1'b0;
                        r_busy     <= 1'b1;
                        if (WAIT_STATES > 0) begin
                            r_state   <= S_WAIT;
                            r_waitCnt <= WAIT_LOAD;
                        end else begin
                            r_state <= S_ACCESS;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_waitCnt == 4'd0) begin
                        r_state <= S_ACCESS;
                    end else begin
                        r_waitCnt <= r_waitCnt - 4'd1;
                    end
                end
                S_ACCESS: begin
                    r_rspErr   <= !w_legal;
                    r_rspRdata <= (w_legal && (r_op == OP_LDR)) ? w_memRdata : '0;
                    r_state    <= S_RESP;
                end
                S_RESP: begin
                    if (!r_rspValid) begin
                        r_rspValid <= 1'b1;
                    end else if (bus.rsp_ready_i) begin
                        r_rspValid <= 1'b0;
                        r_rspRdata <= '0;
                        r_rspErr   <= 1'b0;
                        r_reqReady <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
`ifdef DMEM_RESET_CLEAR_EN
                S_CLEAR: begin
                    if (r_clrAddr == CLR_LAST) begin
                        r_state    <= S_IDLE;
                        r_reqReady <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_clrAddr <= r_clrAddr + 1'b1;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = r_reqReady;
    assign bus.rsp_valid_o = r_rspValid;
    assign bus.rsp_rdata_o = r_rspRdata;
    assign bus.rsp_err_o   = r_rspErr;
    assign busy_o          = r_busy;
endmodule

// File: doc/minimicro_dmem_responder.md
Name: minimicro_dmem_responder

Overview:
Data-memory responder for the minimicro core. It sits on the core's load/store port and serves LDR/STR requests against a DM_ADDRESSES x DATA_WIDTH word array. Requests use a valid/ready channel and responses use a separate valid/ready channel. A programmable number of wait states models slow memory, which stresses the core's stall logic.

Parameters:
DATA_WIDTH, 16, word width in bits; matches the core datapath.
DM_ADDRESSES, 256, number of words in the array.
ADDR_WIDTH, 8, request address width; must satisfy 2**ADDR_WIDTH >= DM_ADDRESSES.
WAIT_STATES, 2, extra cycles between request accept and array access; legal range 0..15.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
req_valid_i  in  1  core presents a request.
req_ready_o  out  1  responder can accept a request.
req_op_i  in  4  opcode_t encoding; LDR=4'b0110, STR=4'b0111; any other value is illegal.
req_addr_i  in  ADDR_WIDTH  word address.
req_wdata_i  in  DATA_WIDTH  store data; used only for STR.
rsp_valid_o  out  1  response available.
rsp_ready_i  in  1  core accepts the response.
rsp_rdata_o  out  DATA_WIDTH  load data; 0 for STR and for error responses.
rsp_err_o  out  1  illegal opcode or address >= DM_ADDRESSES.
busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: FSM=IDLE; req_ready_o=1; rsp_valid_o=0; rsp_rdata_o=0; rsp_err_o=0; busy_o=0; wait counter=0.
- Array contents are not reset, except as described under Optional Feature.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_ready_o=1.
  - When req_valid_i && req_ready_o on a clock edge, capture op, addr and wdata.
  - Go to WAIT if WAIT_STATES>0, else go to ACCESS.
  - req_ready_o is 0 in every state other than IDLE, so only one request is outstanding.
- WAIT:
  - Counter loads WAIT_STATES-1 on accept and decrements each cycle.
  - Go to ACCESS on the cycle the counter reads 0.
  - Request inputs are ignored in this state.
- ACCESS (exactly one cycle):
  - Legal STR: write wdata to mem[addr]; rdata=0; err=0.
  - Legal LDR: rdata=mem[addr]; err=0.
  - Illegal op or out-of-range address: no array write; rdata=0; err=1.
  - Go to RESP.
- RESP:
  - rsp_valid_o=1. rsp_rdata_o and rsp_err_o are registered and held stable while rsp_ready_i=0.
  - On rsp_valid_o && rsp_ready_i, go to IDLE. rsp_valid_o drops and req_ready_o rises on the following cycle. No same-cycle re-accept.
- Latency: with the request accepted at edge k, rsp_valid_o is first high after edge k+WAIT_STATES+2. Minimum is 2 cycles when WAIT_STATES=0.
- Reset mid-operation: the FSM returns to IDLE immediately.
  - A captured STR that has not yet been performed in ACCESS is discarded; the array is unchanged.
  - A reset asserted concurrently with the ACCESS edge suppresses the write.
  - A pending response is dropped.
- Address arithmetic: unsigned compare addr < DM_ADDRESSES. No wrap-around and no aliasing.

Optional Feature:
Macro DMEM_RESET_CLEAR_EN.
- When defined: after rst_n deasserts, the FSM enters an extra CLEAR state that writes 0 to address 0 through DM_ADDRESSES-1, one word per cycle.
  - During CLEAR: req_ready_o=0 and busy_o=1. CLEAR lasts exactly DM_ADDRESSES cycles, then the FSM goes to IDLE.
  - A reset during CLEAR restarts the sweep from address 0.
- When not defined: the CLEAR state does not exist. The FSM is in IDLE directly out of reset and the array contents are undefined until written.

Test Plan:
1. WAIT_STATES=2: STR addr 0x10 wdata 0xBEEF, then LDR addr 0x10 -> STR response has rdata=0, err=0. LDR response has rdata=0xBEEF, err=0. Each rsp_valid_o goes high 4 cycles after its accept edge.
2. Backpressure: LDR 0x10 with rsp_ready_i held at 0 for 5 cycles -> rsp_valid_o=1 and rdata=0xBEEF stable throughout. req_ready_o=0 throughout. req_ready_o=1 one cycle after the handshake.
3. Illegal opcode: req_op_i=ADD (4'b0000), addr 0x10, wdata 0x1234 -> err=1, rdata=0. A following LDR 0x10 still returns 0xBEEF.
4. Out-of-range: DM_ADDRESSES=200, LDR addr 0xC8 -> err=1, rdata=0. LDR addr 0xC7 -> err=0.
5. WAIT_STATES=0: back-to-back STR 0x01/0x00A5 then LDR 0x01 -> each response valid 2 cycles after accept. Load returns 0x00A5.
6. Reset mid-WAIT: pre-store 0x5555 at 0x20. Issue STR 0x20/0xAAAA, then pulse rst_n low during WAIT -> outputs return to reset values. LDR 0x20 returns 0x5555 (without DMEM_RESET_CLEAR_EN) or 0x0000 (with it; req_ready_o stays 0 for 256 cycles after reset).
